trap_ctrl: RTL and testbench

Sequencer in front of the machine-mode CSR file. It arbitrates synchronous exceptions, `mret` requests and (optionally) machine interrupts, and drains the pipeline before trap entry or return. It issues the single-cycle exception/`mret` pulse into the CSR file, then redirects fetch to the CSR-supplied `mtvec` or `mepc`. It sits between the execute/commit stage and the CSR file.

---
 rtl/trap_ctrl.sv | 179 +++++++++++++++++
 tb/tb_trap_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: drains the pipeline, pulses the CSR file for trap entry or mret, then redirects fetch.
// Ports: exc_*/mret_valid/irq lines/drained/mtvec/mepc in; req_ready/flush/csr_*/redirect_*/busy out.
// Define TRAP_CTRL_IRQ_EN to arbitrate machine interrupts (MEI > MSI > MTI) behind exc and mret.
module trap_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_epc,
  input  logic [31:0] exc_tval,
  input  logic        mret_valid,
  input  logic [31:0] next_pc,
  input  logic        next_pc_valid,
  input  logic        meip,
  input  logic        msip,
  input  logic        mtip,
  input  logic        mstatus_mie,
  input  logic [31:0] mie,
  input  logic        drained,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        req_ready,
  output logic        flush,
  output logic        csr_exception,
  output logic        csr_mret,
  output logic [3:0]  csr_ecause,
  output logic        csr_eint,
  output logic [31:0] csr_epc,
  output logic [31:0] csr_etval,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE, FLUSH, COMMIT, REDIRECT
  } state_t;

  typedef enum logic [1:0] {
    K_EXC, K_IRQ, K_MRET
  } kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [3:0]  cause_q, cause_d;
  logic        int_q, int_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] tval_q, tval_d;
  logic        take;
  logic        in_commit;
  logic        in_redir;

`ifdef TRAP_CTRL_IRQ_EN
  logic       mei, msi, mti;
  logic       irq_pend;
  logic [3:0] irq_cause;
  logic       unused_mie;

  assign mei = meip & mie[11];
  assign msi = msip & mie[3];
  assign mti = mtip & mie[7];
  assign irq_pend = mstatus_mie & next_pc_valid
                  & (mei | msi | mti);

  always_comb begin
    irq_cause = 4'd7;
    if (mei)
      irq_cause = 4'd11;
    else if (msi)
      irq_cause = 4'd3;
  end

  assign unused_mie = ^{mie[31:12], mie[10:8],
                        mie[6:4], mie[2:0]};
`else
  logic unused_irq;
  assign unused_irq = ^{meip, msip, mtip, mstatus_mie,
                        mie, next_pc, next_pc_valid, int_q};
`endif

  // Arbitration and field capture; only acts in IDLE.
  always_comb begin
    take    = 1'b0;
    kind_d  = kind_q;
    cause_d = cause_q;
    int_d   = int_q;
    epc_d   = epc_q;
    tval_d  = tval_q;
    if (state_q == IDLE) begin
      priority case (1'b1)
        exc_valid: begin
          take    = 1'b1;
          kind_d  = K_EXC;
          cause_d = exc_cause;
          int_d   = 1'b0;
          epc_d   = exc_epc;
          tval_d  = exc_tval;
        end
        mret_valid: begin
          take    = 1'b1;
          kind_d  = K_MRET;
          cause_d = 4'd0;
          int_d   = 1'b0;
          epc_d   = 32'd0;
          tval_d  = 32'd0;
        end
`ifdef TRAP_CTRL_IRQ_EN
        irq_pend: begin
          take    = 1'b1;
          kind_d  = K_IRQ;
          cause_d = irq_cause;
          int_d   = 1'b1;
          epc_d   = next_pc;
          tval_d  = 32'd0;
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (take) state_d = FLUSH;
      FLUSH:    if (drained) state_d = COMMIT;
      COMMIT:   state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      kind_q  <= K_EXC;
      cause_q <= 4'd0;
      int_q   <= 1'b0;
      epc_q   <= 32'd0;
      tval_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cause_q <= cause_d;
      int_q   <= int_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
    end
  end

  // Interrupts are taken without a handshake; rst gates the
  // combinational path so outputs read 0 while in reset.
  assign req_ready = rst & (state_q == IDLE)
                   & (exc_valid | mret_valid);

  assign in_commit = (state_q == COMMIT);
  assign in_redir  = (state_q == REDIRECT);

  assign busy  = (state_q != IDLE);
  assign flush = busy;

  assign csr_exception = in_commit & (kind_q != K_MRET);
  assign csr_mret      = in_commit & (kind_q == K_MRET);
  assign csr_ecause    = in_commit ? cause_q : 4'd0;
  assign csr_epc       = in_commit ? epc_q : 32'd0;
  assign csr_etval     = in_commit ? tval_q : 32'd0;

`ifdef TRAP_CTRL_IRQ_EN
  assign csr_eint = in_commit & int_q;
`else
  assign csr_eint = 1'b0;
`endif

  // mtvec/mepc already reflect the CSR update from COMMIT.
  assign redirect_valid = in_redir;
  assign redirect_pc    = !in_redir ? 32'd0 :
                          (kind_q == K_MRET) ? mepc : mtvec;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed vector table plus hand sequences for trap_ctrl.
// Covers exception, drain stall, mret, priority collision, reset mid-trap and interrupts.
module tb_trap_ctrl;

  logic        clk;
  logic        rst;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_epc;
  logic [31:0] exc_tval;
  logic        mret_valid;
  logic [31:0] next_pc;
  logic        next_pc_valid;
  logic        meip;
  logic        msip;
  logic        mtip;
  logic        mstatus_mie;
  logic [31:0] mie;
  logic        drained;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        req_ready;
  logic        flush;
  logic        csr_exception;
  logic        csr_mret;
  logic [3:0]  csr_ecause;
  logic        csr_eint;
  logic [31:0] csr_epc;
  logic [31:0] csr_etval;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int n_exc = 0;
  int n_mret = 0;
  int n_redir = 0;

  trap_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_epc        (exc_epc),
    .exc_tval       (exc_tval),
    .mret_valid     (mret_valid),
    .next_pc        (next_pc),
    .next_pc_valid  (next_pc_valid),
    .meip           (meip),
    .msip           (msip),
    .mtip           (mtip),
    .mstatus_mie    (mstatus_mie),
    .mie            (mie),
    .drained        (drained),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .req_ready      (req_ready),
    .flush          (flush),
    .csr_exception  (csr_exception),
    .csr_mret       (csr_mret),
    .csr_ecause     (csr_ecause),
    .csr_eint       (csr_eint),
    .csr_epc        (csr_epc),
    .csr_etval      (csr_etval),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (csr_exception) n_exc <= n_exc + 1;
    if (csr_mret) n_mret <= n_mret + 1;
    if (redirect_valid) n_redir <= n_redir + 1;
  end

  typedef struct {
    logic        is_mret;
    logic [3:0]  cause;
    logic [31:0] epc;
    logic [31:0] tval;
    int          waitc;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [3:0]  x_cause;
    logic [31:0] x_epc;
    logic [31:0] x_tval;
    logic [31:0] x_pc;
    logic        x_exc;
    logic        x_mret;
  } vec_t;

  vec_t vt[4];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1 with the controller idle.
  task automatic run_vec(input vec_t t);
    int e0, m0, r0;
    e0 = n_exc;
    m0 = n_mret;
    r0 = n_redir;
    mtvec      = 32'hFFFF_FFF0;
    mepc       = 32'hFFFF_FFF4;
    exc_valid  = !t.is_mret;
    mret_valid = t.is_mret;
    exc_cause  = t.cause;
    exc_epc    = t.epc;
    exc_tval   = t.tval;
    drained    = 1'b0;
    @(negedge clk);
    chk("accept_ready", {31'd0, req_ready}, 32'd1);
    tick();
    exc_valid  = 1'b0;
    mret_valid = 1'b0;
    exc_cause  = 4'd0;
    exc_epc    = 32'd0;
    exc_tval   = 32'd0;
    for (int k = 0; k <= t.waitc; k++) begin
      drained = (k == t.waitc);
      @(negedge clk);
      chk("flush_phase",
          {28'd0, flush, csr_exception, csr_mret, redirect_valid},
          32'h8);
      tick();
    end
    @(negedge clk);
    chk("commit_exc", {31'd0, csr_exception}, {31'd0, t.x_exc});
    chk("commit_mret", {31'd0, csr_mret}, {31'd0, t.x_mret});
    chk("commit_cause", {28'd0, csr_ecause}, {28'd0, t.x_cause});
    chk("commit_epc", csr_epc, t.x_epc);
    chk("commit_tval", csr_etval, t.x_tval);
    chk("commit_misc", {29'd0, csr_eint, flush, redirect_valid},
        32'h2);
    tick();
    mtvec = t.mtvec;
    mepc  = t.mepc;
    @(negedge clk);
    chk("redir_valid", {30'd0, redirect_valid, csr_exception},
        32'h2);
    chk("redir_pc", redirect_pc, t.x_pc);
    chk("redir_csr_zero", csr_epc, 32'd0);
    tick();
    mtvec = 32'hFFFF_FFF0;
    mepc  = 32'hFFFF_FFF4;
    @(negedge clk);
    chk("back_idle", {29'd0, busy, flush, redirect_valid}, 32'd0);
    chk("exc_pulses", n_exc - e0, {31'd0, t.x_exc});
    chk("mret_pulses", n_mret - m0, {31'd0, t.x_mret});
    chk("redir_pulses", n_redir - r0, 32'd1);
    tick();
  endtask

  initial begin
    int e0;
    vt[0] = '{1'b0, 4'd2, 32'h100, 32'hDEAD, 0, 32'h80, 32'h999,
              4'd2, 32'h100, 32'hDEAD, 32'h80, 1'b1, 1'b0};
    vt[1] = '{1'b0, 4'd5, 32'h2004, 32'h1234, 5, 32'h8000_0100, 32'h0,
              4'd5, 32'h2004, 32'h1234, 32'h8000_0100, 1'b1, 1'b0};
    vt[2] = '{1'b1, 4'hF, 32'hAAAA, 32'hBBBB, 0, 32'h80, 32'h200,
              4'd0, 32'h0, 32'h0, 32'h200, 1'b0, 1'b1};
    vt[3] = '{1'b1, 4'd0, 32'h0, 32'h0, 2, 32'h84, 32'h3000_0004,
              4'd0, 32'h0, 32'h0, 32'h3000_0004, 1'b0, 1'b1};

    rst           = 1'b0;
    exc_valid     = 1'b1;
    exc_cause     = 4'd3;
    exc_epc       = 32'h10;
    exc_tval      = 32'h20;
    mret_valid    = 1'b1;
    next_pc       = 32'd0;
    next_pc_valid = 1'b0;
    meip          = 1'b0;
    msip          = 1'b0;
    mtip          = 1'b0;
    mstatus_mie   = 1'b0;
    mie           = 32'd0;
    drained       = 1'b1;
    mtvec         = 32'h80;
    mepc          = 32'h200;

    @(negedge clk);
    chk("reset_ctrl",
        {26'd0, req_ready, flush, busy, csr_exception,
         csr_mret, redirect_valid}, 32'd0);
    chk("reset_data", csr_epc | csr_etval | redirect_pc, 32'd0);
    exc_valid  = 1'b0;
    mret_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 4; i++)
      run_vec(vt[i]);

    // exc + mret + msip together: exception first, mret next.
    exc_valid     = 1'b1;
    mret_valid    = 1'b1;
    exc_cause     = 4'd4;
    exc_epc       = 32'h500;
    exc_tval      = 32'h77;
    msip          = 1'b1;
    mie           = 32'h8;
    mstatus_mie   = 1'b1;
    next_pc       = 32'h600;
    next_pc_valid = 1'b1;
    drained       = 1'b1;
    mtvec         = 32'h80;
    mepc          = 32'h200;
    @(negedge clk);
    chk("coll_accept", {31'd0, req_ready}, 32'd1);
    tick();
    exc_valid = 1'b0;
    @(negedge clk);
    chk("coll_hold", {30'd0, busy, req_ready}, 32'h2);
    tick();
    @(negedge clk);
    chk("coll_commit",
        {30'd0, csr_exception, csr_mret}, 32'h2);
    chk("coll_cause", {28'd0, csr_ecause}, 32'd4);
    chk("coll_epc", csr_epc, 32'h500);
    chk("coll_eint", {31'd0, csr_eint}, 32'd0);
    tick();
    @(negedge clk);
    chk("coll_redir", redirect_pc, 32'h80);
    tick();
    @(negedge clk);
    chk("coll_mret_acc", {30'd0, busy, req_ready}, 32'h1);
    tick();
    mret_valid  = 1'b0;
    msip        = 1'b0;
    mstatus_mie = 1'b0;
    tick();
    @(negedge clk);
    chk("coll_mret_pulse",
        {30'd0, csr_exception, csr_mret}, 32'h1);
    tick();
    @(negedge clk);
    chk("coll_mret_pc", redirect_pc, 32'h200);
    tick();
    @(negedge clk);
    chk("coll_idle", {31'd0, busy}, 32'd0);
    tick();

`ifdef TRAP_CTRL_IRQ_EN
    meip          = 1'b1;
    mtip          = 1'b1;
    mie           = 32'h880;
    mstatus_mie   = 1'b1;
    next_pc       = 32'h40;
    next_pc_valid = 1'b1;
    exc_tval      = 32'h55;
    mtvec         = 32'h80;
    @(negedge clk);
    chk("irq_no_ready", {31'd0, req_ready}, 32'd0);
    tick();
    meip = 1'b0;
    mtip = 1'b0;
    @(negedge clk);
    chk("irq_busy", {31'd0, busy}, 32'd1);
    tick();
    @(negedge clk);
    chk("irq_commit", {31'd0, csr_exception}, 32'd1);
    chk("irq_cause", {28'd0, csr_ecause}, 32'd11);
    chk("irq_eint", {31'd0, csr_eint}, 32'd1);
    chk("irq_epc", csr_epc, 32'h40);
    chk("irq_tval", csr_etval, 32'd0);
    tick();
    @(negedge clk);
    chk("irq_redir", redirect_pc, 32'h80);
    tick();
    mstatus_mie = 1'b0;
    meip        = 1'b1;
    mtip        = 1'b1;
    e0 = n_exc;
    repeat (3) tick();
    @(negedge clk);
    chk("irq_masked", {31'd0, busy}, 32'd0);
    chk("irq_masked_pulses", n_exc - e0, 32'd0);
`else
    meip          = 1'b1;
    msip          = 1'b1;
    mtip          = 1'b1;
    mie           = 32'hFFFF_FFFF;
    mstatus_mie   = 1'b1;
    next_pc_valid = 1'b1;
    e0 = n_exc;
    repeat (3) tick();
    @(negedge clk);
    chk("irq_ignored", {31'd0, busy}, 32'd0);
    chk("irq_ignored_pulses", n_exc - e0, 32'd0);
`endif
    meip          = 1'b0;
    msip          = 1'b0;
    mtip          = 1'b0;
    mstatus_mie   = 1'b0;
    next_pc_valid = 1'b0;
    tick();

    // Reset while draining: outputs drop at once, no CSR pulse.
    e0 = n_exc;
    exc_valid = 1'b1;
    exc_cause = 4'd6;
    drained   = 1'b0;
    tick();
    exc_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_flush", {31'd0, flush}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_ctrl",
        {26'd0, req_ready, flush, busy, csr_exception,
         csr_mret, redirect_valid}, 32'd0);
    chk("rst_async_data", csr_epc | csr_etval | redirect_pc, 32'd0);
    drained = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("rst_idle", {31'd0, busy}, 32'd0);
    chk("rst_no_pulse", n_exc - e0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
